// File: rtl/nios_ii_cpu_div_pkg.sv
// Shared definitions for the Nios II gen2 iterative divider.
package nios_ii_cpu_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Start-to-done latency in clock cycles, including the FIX cycle.
    localparam int DIV_LATENCY = 34;

    // Quotient reported for any divide-by-zero, signed or unsigned.
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFFFFFF;

endpackage

// File: rtl/nios_ii_cpu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, restore on borrow.
module nios_ii_cpu_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic              dvd_msb,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic              quot_bit
);

    // Two guard bits: the shifted remainder needs DATA_W+1 bits, plus one
    // more to expose the borrow of the trial subtraction.
    logic [DATA_W+1:0] diff;
    logic              borrow;

    assign diff     = {1'b0, rem, dvd_msb} - {2'b00, divisor};
    assign borrow   = diff[DATA_W+1];
    assign quot_bit = ~borrow;
    // After a successful subtraction the difference is below the divisor,
    // so it always fits back into DATA_W bits.
    assign rem_next = borrow ? {rem[DATA_W-2:0], dvd_msb} : diff[DATA_W-1:0];

endmodule

// File: rtl/nios_ii_cpu_div_cell.sv
// Iterative radix-2 restoring divider serving div/divu. Fixed 34-cycle
// latency, registered busy/done/results, flush abort.
module nios_ii_cpu_div_cell
    import nios_ii_cpu_div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic              E_div_start,
    input  logic              E_div_signed,
    input  logic              M_flush,
    output logic              M_div_busy,
    output logic              M_div_done,
    output logic [DATA_W-1:0] M_div_quot,
    output logic [DATA_W-1:0] M_div_rem
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    div_state_e        state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] dvd;       // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0] dvs;       // divisor magnitude
    logic [DATA_W-1:0] rem_acc;   // partial remainder
    logic [DATA_W-1:0] src1_orig; // raw dividend, returned as rem on divide-by-zero
    logic              quot_neg;
    logic              rem_neg;
    logic              div_zero;

    // Operand magnitudes; 0x80000000 negates to itself, which is the
    // correct unsigned magnitude.
    logic              sign1;
    logic              sign2;
    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;

    assign sign1 = E_div_signed & E_src1[DATA_W-1];
    assign sign2 = E_div_signed & E_src2[DATA_W-1];
    assign mag1  = sign1 ? -E_src1 : E_src1;
    assign mag2  = sign2 ? -E_src2 : E_src2;

    logic [DATA_W-1:0] rem_next;
    logic              quot_bit;

    nios_ii_cpu_div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem      (rem_acc),
        .dvd_msb  (dvd[DATA_W-1]),
        .divisor  (dvs),
        .rem_next (rem_next),
        .quot_bit (quot_bit)
    );

    // Final results with divide-by-zero override and sign fixup.
    logic [DATA_W-1:0] quot_fix;
    logic [DATA_W-1:0] rem_fix;

    assign quot_fix = div_zero ? DIV_ZERO_QUOT[DATA_W-1:0] : (quot_neg ? -dvd : dvd);
    assign rem_fix  = div_zero ? src1_orig : (rem_neg ? -rem_acc : rem_acc);

    // Control FSM and datapath registers; flush dominates every other input.
    // NOTE: the reset is in the sensitivity list so it acts without a clock;
    // every register, results included, returns to a known zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            dvd        <= '0;
            dvs        <= '0;
            rem_acc    <= '0;
            src1_orig  <= '0;
            quot_neg   <= 1'b0;
            rem_neg    <= 1'b0;
            div_zero   <= 1'b0;
            M_div_busy <= 1'b0;
            M_div_done <= 1'b0;
            M_div_quot <= '0;
            M_div_rem  <= '0;
        end else if (M_flush) begin
            // NOTE: non-blocking assignments throughout, so every register
            // sees the pre-edge values regardless of statement order.
            state      <= IDLE;
            M_div_busy <= 1'b0;
            M_div_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    M_div_done <= 1'b0;
                    if (E_div_start) begin
                        dvd        <= mag1;
                        dvs        <= mag2;
                        src1_orig  <= E_src1;
                        rem_acc    <= '0;
                        quot_neg   <= sign1 ^ sign2;
                        rem_neg    <= sign1;
                        div_zero   <= (E_src2 == '0);
                        count      <= CNT_W'(DATA_W);
                        M_div_busy <= 1'b1;
                        state      <= ITER;
                    end
                end
                ITER: begin
                    rem_acc <= rem_next;
                    dvd     <= {dvd[DATA_W-2:0], quot_bit};
                    count   <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    M_div_quot <= quot_fix;
                    M_div_rem  <= rem_fix;
                    M_div_done <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    M_div_done <= 1'b0;
                    M_div_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    M_div_done <= 1'b0;
                    M_div_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_ii_cpu_div_cell.sv
// Directed and model-based bench for nios_ii_cpu_div_cell.
module tb_nios_ii_cpu_div_cell;

    logic        clk;
    logic        reset_n;
    logic [31:0] E_src1;
    logic [31:0] E_src2;
    logic        E_div_start;
    logic        E_div_signed;
    logic        M_flush;
    logic        M_div_busy;
    logic        M_div_done;
    logic [31:0] M_div_quot;
    logic [31:0] M_div_rem;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;

    nios_ii_cpu_div_cell #(
        .DATA_W (32)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .E_src1       (E_src1),
        .E_src2       (E_src2),
        .E_div_start  (E_div_start),
        .E_div_signed (E_div_signed),
        .M_flush      (M_flush),
        .M_div_busy   (M_div_busy),
        .M_div_done   (M_div_done),
        .M_div_quot   (M_div_quot),
        .M_div_rem    (M_div_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: truncating division, remainder takes dividend sign.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'h0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'h0, a});
                sb = longint'({32'h0, b});
            end
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    // Start a division in the current cycle (cycle 0) and watch cycles 1..35.
    // poke > 0 re-asserts start with different operands in that cycle.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                          input int poke);
        int          done_cyc;
        int          busy_bad;
        logic [31:0] q;
        logic [31:0] r;
        done_cyc = -1;
        busy_bad = 0;
        q = '0;
        r = '0;
        E_src1 = a;
        E_src2 = b;
        E_div_signed = sgn;
        E_div_start = 1'b1;
        for (int n = 1; n <= 35; n++) begin
            next_cycle();
            E_div_start = 1'b0;
            if (n == poke) begin
                E_src1 = ~a;
                E_src2 = b + 32'd3;
                E_div_signed = ~sgn;
                E_div_start = 1'b1;
            end
            if (M_div_busy !== (n <= 34)) busy_bad++;
            if (M_div_done === 1'b1) begin
                if (done_cyc < 0) begin
                    done_cyc = n;
                    q = M_div_quot;
                    r = M_div_rem;
                end else begin
                    done_cyc = 99;
                end
            end
        end
        E_div_start = 1'b0;
        check({tag, " done_cycle"}, done_cyc, 34);
        check({tag, " busy_window_errs"}, busy_bad, 0);
        check({tag, " quot"}, q, eq);
        check({tag, " rem"}, r, er);
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        int          dones;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [31:0] mq;
        logic [31:0] mr;

        reset_n = 1'b0;
        E_src1 = '0;
        E_src2 = '0;
        E_div_start = 1'b0;
        E_div_signed = 1'b0;
        M_flush = 1'b0;
        #2;
        check("reset busy", {31'b0, M_div_busy}, 32'd0);
        check("reset done", {31'b0, M_div_done}, 32'd0);
        check("reset quot", M_div_quot, 32'd0);
        check("reset rem", M_div_rem, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        next_cycle();

        // Directed vectors, each started back-to-back in cycle 35 of the previous.
        do_div("u 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 0);
        do_div("s -100/7", 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 0);
        do_div("s 100/-7", 32'd100, 32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2, 0);
        do_div("u div0", 32'h12345678, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 0);
        do_div("s div0", 32'h12345678, 32'h0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 0);
        do_div("s -5/0", 32'hFFFFFFFB, 32'h0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 0);
        do_div("s min/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0, 0);
        do_div("u max/1", 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'h0, 0);
        do_div("u min/-1", 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h80000000, 0);
        do_div("restart ignored", 32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 5);

        // Flush at cycle 10: no done, idle at cycle 11, results held.
        dones = 0;
        E_src1 = 32'd5000;
        E_src2 = 32'd3;
        E_div_signed = 1'b0;
        E_div_start = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            next_cycle();
            E_div_start = 1'b0;
            if (n == 10) M_flush = 1'b1;
            if (n == 11) M_flush = 1'b0;
            if (M_div_done === 1'b1) dones++;
        end
        check("flush no_done", dones, 0);
        check("flush busy@11", {31'b0, M_div_busy}, 32'd0);
        check("flush quot held", M_div_quot, last_q);
        check("flush rem held", M_div_rem, last_r);
        do_div("after flush (done@45)", 32'd77, 32'd5, 1'b0, 32'd15, 32'd2, 0);

        // Flush together with start in IDLE drops the start.
        E_src1 = 32'd9;
        E_src2 = 32'd2;
        E_div_start = 1'b1;
        M_flush = 1'b1;
        next_cycle();
        E_div_start = 1'b0;
        M_flush = 1'b0;
        check("flush+start busy", {31'b0, M_div_busy}, 32'd0);
        next_cycle();
        check("flush+start busy2", {31'b0, M_div_busy}, 32'd0);

        // Asynchronous reset in the middle of an operation.
        E_src1 = 32'd999;
        E_src2 = 32'd10;
        E_div_start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            next_cycle();
            E_div_start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("midreset busy", {31'b0, M_div_busy}, 32'd0);
        check("midreset done", {31'b0, M_div_done}, 32'd0);
        check("midreset quot", M_div_quot, 32'd0);
        check("midreset rem", M_div_rem, 32'd0);
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        do_div("after reset", 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14, 32'hFFFFFFFE, 0);

        // Randomised regression against the model, back-to-back.
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 1) rb = rb >> $urandom_range(16, 30);
            if (i % 3 == 2) rb = -(rb >> $urandom_range(20, 30));
            rs = i[0];
            ref_div(ra, rb, rs, mq, mr);
            do_div($sformatf("rand%0d", i), ra, rb, rs, mq, mr, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
